// File: rtl/axi4_burst_checker_pkg.sv
// Shared types and constants for the AXI4 burst write/readback checker.
package axi4_burst_checker_pkg;

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FIN} state_t;

  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Conservative 4 KB check: either bursts tile 4 KB pages exactly, or the whole run fits one page.
  function automatic bit layout_ok(input logic [63:0] base, input longint unsigned step,
                                   input longint unsigned n);
    longint unsigned off;
    off = base % 64'd4096;
    return ((64'd4096 % step == 64'd0) && (base % step == 64'd0)) || (off + n * step <= 64'd4096);
  endfunction

endpackage

// File: rtl/axi4_burst_checker_if.sv
// AXI4 subset used by the burst checker: AW/W/B/AR/R with fixed ID 0.
interface axi4_burst_checker_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_burst_checker_patgen.sv
// Data pattern source: SEED+n counter, or 32-bit Galois LFSR when AXI4_BURST_CHECKER_LFSR_EN is defined.
module axi4_burst_checker_patgen
  import axi4_burst_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter logic [31:0] SEED   = 32'h1234_5678
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] data
);

`ifdef AXI4_BURST_CHECKER_LFSR_EN
  logic [31:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr <= SEED;
    else if (load) lfsr <= SEED;
    else if (step) lfsr <= lfsr_next(lfsr);
  end

  if (DATA_W == 64) begin : g_w64
    assign data = {lfsr, ~lfsr};
  end else begin : g_w32
    assign data = lfsr;
  end
`else
  logic [DATA_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= DATA_W'(SEED);
    else if (load) cnt <= DATA_W'(SEED);
    else if (step) cnt <= cnt + 1'b1;
  end

  assign data = cnt;
`endif

endmodule

// File: rtl/axi4_burst_checker.sv
// AXI4 master: writes NUM_BURSTS INCR bursts of a known pattern, reads them back and compares.
// Pattern selection via AXI4_BURST_CHECKER_LFSR_EN (see axi4_burst_checker_patgen).
module axi4_burst_checker
  import axi4_burst_checker_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       BURST_LEN  = 16,
  parameter int unsigned       NUM_BURSTS = 4,
  parameter logic [31:0]       SEED       = 32'h1234_5678
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 START,
  output logic                 DONE,
  output logic                 ERROR,
  axi4_burst_checker_if.master M_AXI
);

  localparam int unsigned       BYTES       = DATA_W / 8;
  localparam int unsigned       BURST_BYTES = BURST_LEN * BYTES;
  localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(BURST_BYTES);
  localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0]       LAST_BURST  = 16'(NUM_BURSTS - 1);
  localparam logic [2:0]        AXSIZE      = 3'($clog2(BYTES));

  if (!(DATA_W == 32 || DATA_W == 64) || BURST_LEN == 0 || BURST_LEN > 256 ||
      NUM_BURSTS == 0 || NUM_BURSTS > 65535 ||
      !layout_ok(64'(BASE_ADDR), BURST_BYTES, NUM_BURSTS)) begin : g_param_check
    $error("axi4_burst_checker: illegal parameters or a burst crosses a 4 KB boundary");
  end

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        beat;
  logic [15:0]       burst;
  logic              awvalid, wvalid, wlast, bready, arvalid, rready;
  logic              pat_load, pat_step;
  logic [DATA_W-1:0] pat;

  // One generator serves both phases; it is reloaded when the read phase begins.
  always_comb begin
    pat_load = (state == B) && M_AXI.bvalid && (burst == LAST_BURST);
    pat_step = ((state == W) && M_AXI.wready) || ((state == R) && M_AXI.rvalid);
  end

  axi4_burst_checker_patgen #(.DATA_W(DATA_W), .SEED(SEED)) u_patgen (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .load  (pat_load),
    .step  (pat_step),
    .data  (pat)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      addr    <= BASE_ADDR;
      beat    <= '0;
      burst   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      DONE    <= 1'b0;
      ERROR   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          awvalid <= 1'b1;
          state   <= AW;
        end
        AW: if (M_AXI.awready) begin
          awvalid <= 1'b0;
          wvalid  <= 1'b1;
          wlast   <= (LAST_BEAT == 8'd0);
          beat    <= '0;
          state   <= W;
        end
        W: if (M_AXI.wready) begin
          if (wlast) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
            bready <= 1'b1;
            state  <= B;
          end else begin
            beat  <= beat + 8'd1;
            wlast <= (beat + 8'd1 == LAST_BEAT);
          end
        end
        B: if (M_AXI.bvalid) begin
          bready <= 1'b0;
          if (M_AXI.bresp != RESP_OKAY) ERROR <= 1'b1;
          if (burst == LAST_BURST) begin
            burst   <= '0;
            addr    <= BASE_ADDR;
            arvalid <= 1'b1;
            state   <= AR;
          end else begin
            burst   <= burst + 16'd1;
            addr    <= addr + STEP;
            awvalid <= 1'b1;
            state   <= AW;
          end
        end
        AR: if (M_AXI.arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          beat    <= '0;
          state   <= R;
        end
        // Burst ends on beat count, not RLAST, so a missing RLAST cannot hang the run.
        R: if (M_AXI.rvalid) begin
          if ((M_AXI.rdata != pat) || (M_AXI.rresp != RESP_OKAY) ||
              (M_AXI.rlast != (beat == LAST_BEAT))) ERROR <= 1'b1;
          if (beat == LAST_BEAT) begin
            rready <= 1'b0;
            if (burst == LAST_BURST) begin
              DONE  <= 1'b1;
              state <= FIN;
            end else begin
              burst   <= burst + 16'd1;
              addr    <= addr + STEP;
              arvalid <= 1'b1;
              state   <= AR;
            end
          end else begin
            beat <= beat + 8'd1;
          end
        end
        FIN: state <= FIN;
        default: state <= IDLE;
      endcase
    end
  end

  assign M_AXI.awaddr  = addr;
  assign M_AXI.awlen   = LAST_BEAT;
  assign M_AXI.awsize  = AXSIZE;
  assign M_AXI.awburst = BURST_INCR;
  assign M_AXI.awvalid = awvalid;
  assign M_AXI.wdata   = pat;
  assign M_AXI.wstrb   = '1;
  assign M_AXI.wlast   = wlast;
  assign M_AXI.wvalid  = wvalid;
  assign M_AXI.bready  = bready;
  assign M_AXI.araddr  = addr;
  assign M_AXI.arlen   = LAST_BEAT;
  assign M_AXI.arsize  = AXSIZE;
  assign M_AXI.arburst = BURST_INCR;
  assign M_AXI.arvalid = arvalid;
  assign M_AXI.rready  = rready;

endmodule
